// File: rtl/hp_vpu_wb_arb.sv
// VRF write-port arbiter: merges the E3 pipe, a queued reduction path and a
// multicycle handshake onto one registered VRF write port, with starvation bubbles.
module hp_vpu_wb_arb #(
  parameter int unsigned DLEN       = 64,
  parameter int unsigned RED_DEPTH  = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   pipe_valid_i,
  input  logic [4:0]             pipe_vd_i,
  input  logic [DLEN-1:0]        pipe_data_i,
  input  logic [DLEN/8-1:0]      pipe_be_i,
  input  logic                   red_valid_i,
  input  logic [4:0]             red_vd_i,
  input  logic [DLEN-1:0]        red_data_i,
  input  logic [DLEN/8-1:0]      red_be_i,
  output logic                   red_ready_o,
  input  logic                   mc_valid_i,
  input  logic [4:0]             mc_vd_i,
  input  logic [DLEN-1:0]        mc_data_i,
  input  logic [DLEN/8-1:0]      mc_be_i,
  output logic                   mc_ready_o,
  output logic                   vrf_we_o,
  output logic [4:0]             vrf_waddr_o,
  output logic [DLEN-1:0]        vrf_wdata_o,
  output logic [DLEN/8-1:0]      vrf_wbe_o,
  output logic                   wb_stall_o,
  output logic [RED_DEPTH-1:0]   pend_valid_o,
  output logic [5*RED_DEPTH-1:0] pend_vd_o
);
  localparam int unsigned BEW = DLEN / 8;
  localparam int unsigned PW  = $clog2(RED_DEPTH);
  localparam int unsigned CW  = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {GNT_NONE, GNT_PIPE, GNT_RED, GNT_MC} gnt_e;

  logic [RED_DEPTH-1:0] occ_q, occ_d;
  logic [4:0]           qvd_q   [RED_DEPTH];
  logic [4:0]           qvd_d   [RED_DEPTH];
  logic [DLEN-1:0]      qdata_q [RED_DEPTH];
  logic [DLEN-1:0]      qdata_d [RED_DEPTH];
  logic [BEW-1:0]       qbe_q   [RED_DEPTH];
  logic [BEW-1:0]       qbe_d   [RED_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 last_np_q, last_np_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [4:0]           waddr_q, waddr_d;
  logic [DLEN-1:0]      wdata_q, wdata_d;
  logic [BEW-1:0]       wbe_q, wbe_d;

  gnt_e gnt;
  logic stall, full, q_req, m_req, enq;

  always_comb begin
    stall = (cnt_q == CW'(STARVE_MAX));
    full  = &occ_q;
    q_req = |occ_q;
    m_req = mc_valid_i;
    gnt   = GNT_NONE;
    if (!flush_i) begin
      if (pipe_valid_i && !stall) gnt = GNT_PIPE;
      else if (q_req && m_req)    gnt = last_np_q ? GNT_MC : GNT_RED;
      else if (q_req)             gnt = GNT_RED;
      else if (m_req)             gnt = GNT_MC;
    end
    enq = red_valid_i && !full && !flush_i;

    occ_d     = occ_q;
    qvd_d     = qvd_q;
    qdata_d   = qdata_q;
    qbe_d     = qbe_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    last_np_d = last_np_q;
    cnt_d     = '0;
    we_d      = (gnt != GNT_NONE);
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wbe_d     = wbe_q;

    if (flush_i) begin
      occ_d     = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      last_np_d = 1'b0;
    end else begin
      // Dequeue clears its slot before enqueue sets one, so a shared slot ends occupied.
      if (gnt == GNT_RED) begin
        occ_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + PW'(1);
      end
      if (enq) begin
        occ_d[wr_ptr_q]   = 1'b1;
        qvd_d[wr_ptr_q]   = red_vd_i;
        qdata_d[wr_ptr_q] = red_data_i;
        qbe_d[wr_ptr_q]   = red_be_i;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (gnt == GNT_PIPE && (q_req || m_req)) cnt_d = cnt_q + CW'(1);
    end

    case (gnt)
      GNT_PIPE: begin
        waddr_d = pipe_vd_i;
        wdata_d = pipe_data_i;
        wbe_d   = pipe_be_i;
      end
      GNT_RED: begin
        waddr_d   = qvd_q[rd_ptr_q];
        wdata_d   = qdata_q[rd_ptr_q];
        wbe_d     = qbe_q[rd_ptr_q];
        last_np_d = 1'b1;
      end
      GNT_MC: begin
        waddr_d   = mc_vd_i;
        wdata_d   = mc_data_i;
        wbe_d     = mc_be_i;
        last_np_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      last_np_q <= 1'b0;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wbe_q     <= '0;
      for (int unsigned i = 0; i < RED_DEPTH; i++) begin
        qvd_q[i]   <= '0;
        qdata_q[i] <= '0;
        qbe_q[i]   <= '0;
      end
    end else begin
      occ_q     <= occ_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      last_np_q <= last_np_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wbe_q     <= wbe_d;
      qvd_q     <= qvd_d;
      qdata_q   <= qdata_d;
      qbe_q     <= qbe_d;
    end
  end

  always_comb begin
    pend_vd_o = '0;
    for (int unsigned i = 0; i < RED_DEPTH; i++)
      if (occ_q[i]) pend_vd_o[5*i +: 5] = qvd_q[i];
  end

  assign pend_valid_o = occ_q;
  assign red_ready_o  = !full;
  assign mc_ready_o   = (gnt == GNT_MC) && !rst;
  assign wb_stall_o   = stall;
  assign vrf_we_o     = we_q;
  assign vrf_waddr_o  = waddr_q;
  assign vrf_wdata_o  = wdata_q;
  assign vrf_wbe_o    = wbe_q;
endmodule

// File: tb/tb_hp_vpu_wb_arb.sv
// Bench for hp_vpu_wb_arb: directed vector table, hand sequences for starvation
// and async reset, then random traffic against a queue-based reference model.
module tb_hp_vpu_wb_arb;
  localparam int DL = 64;
  localparam int RD = 2;
  localparam int SM = 8;

  logic clk = 1'b0;
  logic rst;
  logic flush_i;
  logic pipe_valid_i, red_valid_i, mc_valid_i;
  logic [4:0] pipe_vd_i, red_vd_i, mc_vd_i;
  logic [DL-1:0] pipe_data_i, red_data_i, mc_data_i;
  logic [DL/8-1:0] pipe_be_i, red_be_i, mc_be_i;
  logic red_ready_o, mc_ready_o, vrf_we_o, wb_stall_o;
  logic [4:0] vrf_waddr_o;
  logic [DL-1:0] vrf_wdata_o;
  logic [DL/8-1:0] vrf_wbe_o;
  logic [RD-1:0] pend_valid_o;
  logic [5*RD-1:0] pend_vd_o;

  hp_vpu_wb_arb #(.DLEN(DL), .RED_DEPTH(RD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .pipe_valid_i(pipe_valid_i), .pipe_vd_i(pipe_vd_i), .pipe_data_i(pipe_data_i), .pipe_be_i(pipe_be_i),
    .red_valid_i(red_valid_i), .red_vd_i(red_vd_i), .red_data_i(red_data_i), .red_be_i(red_be_i),
    .red_ready_o(red_ready_o),
    .mc_valid_i(mc_valid_i), .mc_vd_i(mc_vd_i), .mc_data_i(mc_data_i), .mc_be_i(mc_be_i),
    .mc_ready_o(mc_ready_o),
    .vrf_we_o(vrf_we_o), .vrf_waddr_o(vrf_waddr_o), .vrf_wdata_o(vrf_wdata_o), .vrf_wbe_o(vrf_wbe_o),
    .wb_stall_o(wb_stall_o), .pend_valid_o(pend_valid_o), .pend_vd_o(pend_vd_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: an ordered list of queued results, the physical slot of
  // the oldest one, the round-robin bit and the count of consecutive losses.
  typedef struct packed {
    logic [4:0]      vd;
    logic [DL-1:0]   data;
    logic [DL/8-1:0] be;
  } ent_t;

  ent_t            mq[$];
  int              m_head, m_cnt;
  bit              m_last, m_we, m_acc_m, m_acc_r;
  logic [4:0]      m_waddr;
  logic [DL-1:0]   m_wdata;
  logic [DL/8-1:0] m_wbe;

  task automatic model_reset();
    mq.delete();
    m_head = 0; m_cnt = 0; m_last = 0; m_we = 0;
    m_waddr = '0; m_wdata = '0; m_wbe = '0;
  endtask

  task automatic pre_edge();
    int win, sz, slot;
    bit stall;
    ent_t e;
    logic [RD-1:0] epv;
    logic [5*RD-1:0] epvd;
    #3;
    stall = (m_cnt == SM);
    sz = mq.size();
    win = 0;
    if (!flush_i) begin
      if (pipe_valid_i && !stall)    win = 1;
      else if (sz > 0 && mc_valid_i) win = m_last ? 3 : 2;
      else if (sz > 0)               win = 2;
      else if (mc_valid_i)           win = 3;
    end
    epv = '0; epvd = '0;
    for (int k = 0; k < sz; k++) begin
      slot = (m_head + k) % RD;
      epv[slot] = 1'b1;
      epvd[5*slot +: 5] = mq[k].vd;
    end
    chk("mc_ready", mc_ready_o, win == 3);
    chk("red_ready", red_ready_o, sz < RD);
    chk("wb_stall", wb_stall_o, stall);
    chk("pend_valid", pend_valid_o, epv);
    chk("pend_vd", pend_vd_o, epvd);

    m_acc_m = (win == 3);
    m_acc_r = !flush_i && red_valid_i && (sz < RD);
    if (flush_i) begin
      mq.delete(); m_head = 0; m_cnt = 0; m_last = 0; m_we = 0;
    end else begin
      if (win == 2 || win == 3 || !(sz > 0 || mc_valid_i)) m_cnt = 0;
      else m_cnt++;
      m_we = (win != 0);
      if (win == 1) begin
        m_waddr = pipe_vd_i; m_wdata = pipe_data_i; m_wbe = pipe_be_i;
      end else if (win == 2) begin
        e = mq.pop_front();
        m_head = (m_head + 1) % RD;
        m_waddr = e.vd; m_wdata = e.data; m_wbe = e.be; m_last = 1;
      end else if (win == 3) begin
        m_waddr = mc_vd_i; m_wdata = mc_data_i; m_wbe = mc_be_i; m_last = 0;
      end
      if (m_acc_r) mq.push_back('{vd: red_vd_i, data: red_data_i, be: red_be_i});
    end
  endtask

  task automatic post_edge();
    @(posedge clk); #1;
    chk("vrf_we", vrf_we_o, m_we);
    chk("vrf_waddr", vrf_waddr_o, m_waddr);
    chk("vrf_wdata", vrf_wdata_o, m_wdata);
    chk("vrf_wbe", vrf_wbe_o, m_wbe);
  endtask

  task automatic set_in(input bit pv, input logic [4:0] pvd, input bit rv, input logic [4:0] rvd,
                        input bit mv, input logic [4:0] mvd, input bit fl);
    pipe_valid_i = pv; pipe_vd_i = pvd; pipe_data_i = {8{3'b101, pvd}}; pipe_be_i = 8'hFF;
    red_valid_i  = rv; red_vd_i  = rvd; red_data_i  = {8{rvd, 3'b010}}; red_be_i  = 8'h0F;
    mc_valid_i   = mv; mc_vd_i   = mvd; mc_data_i   = {8{mvd, 3'b110}}; mc_be_i   = 8'hF0;
    flush_i      = fl;
  endtask

  typedef struct {
    bit pv; logic [4:0] pvd; bit rv; logic [4:0] rvd; bit mv; logic [4:0] mvd; bit fl;
    bit e_mcr; bit e_rr; bit e_we; logic [4:0] e_wa; logic [1:0] e_pv;
  } vec_t;

  function automatic vec_t mk(bit pv, int pvd, bit rv, int rvd, bit mv, int mvd, bit fl,
                              bit e_mcr, bit e_rr, bit e_we, int e_wa, logic [1:0] e_pv);
    vec_t v;
    v.pv = pv; v.pvd = 5'(pvd); v.rv = rv; v.rvd = 5'(rvd); v.mv = mv; v.mvd = 5'(mvd); v.fl = fl;
    v.e_mcr = e_mcr; v.e_rr = e_rr; v.e_we = e_we; v.e_wa = 5'(e_wa); v.e_pv = e_pv;
    return v;
  endfunction

  vec_t tbl[20];
  bit   mv_hold, rv_hold;

  initial begin
    // pipe only, queue fill under pipe pressure, round robin, flush
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  2'b00);
    tbl[1]  = mk(1, 3, 0, 0, 0, 0, 0,  0, 1, 1, 3,  2'b00);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  2'b00);
    tbl[3]  = mk(1,10, 1, 1, 0, 0, 0,  0, 1, 1,10,  2'b01);
    tbl[4]  = mk(1,11, 1, 2, 0, 0, 0,  0, 1, 1,11,  2'b11);
    tbl[5]  = mk(1,12, 1, 3, 0, 0, 0,  0, 0, 1,12,  2'b11);
    tbl[6]  = mk(0, 0, 1, 3, 0, 0, 0,  0, 0, 1, 1,  2'b10);
    tbl[7]  = mk(0, 0, 1, 3, 0, 0, 0,  0, 1, 1, 2,  2'b01);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 3,  2'b00);
    tbl[9]  = mk(0, 0, 0, 0, 1,30, 0,  1, 1, 1,30,  2'b00);
    tbl[10] = mk(1,20, 1, 4, 0, 0, 0,  0, 1, 1,20,  2'b10);
    tbl[11] = mk(1,21, 1, 5, 0, 0, 0,  0, 1, 1,21,  2'b11);
    tbl[12] = mk(0, 0, 0, 0, 1, 9, 0,  0, 0, 1, 4,  2'b01);
    tbl[13] = mk(0, 0, 0, 0, 1, 9, 0,  1, 1, 1, 9,  2'b01);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 5,  2'b00);
    tbl[15] = mk(1,22, 1, 6, 1, 8, 0,  0, 1, 1,22,  2'b10);
    tbl[16] = mk(1,23, 1, 7, 1, 8, 0,  0, 1, 1,23,  2'b11);
    tbl[17] = mk(0, 0, 0, 0, 1, 8, 1,  0, 0, 0, 0,  2'b00);
    tbl[18] = mk(0, 0, 0, 0, 1, 8, 0,  1, 1, 1, 8,  2'b00);
    tbl[19] = mk(0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0,  2'b00);

    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", vrf_we_o, 0);
    chk("rst_waddr", vrf_waddr_o, 0);
    chk("rst_wdata", vrf_wdata_o, 0);
    chk("rst_wbe", vrf_wbe_o, 0);
    chk("rst_stall", wb_stall_o, 0);
    chk("rst_pend", pend_valid_o, 0);
    chk("rst_red_ready", red_ready_o, 1);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      set_in(tbl[i].pv, tbl[i].pvd, tbl[i].rv, tbl[i].rvd, tbl[i].mv, tbl[i].mvd, tbl[i].fl);
      pre_edge();
      chk($sformatf("tbl%0d_mc_ready", i), mc_ready_o, tbl[i].e_mcr);
      chk($sformatf("tbl%0d_red_ready", i), red_ready_o, tbl[i].e_rr);
      post_edge();
      chk($sformatf("tbl%0d_we", i), vrf_we_o, tbl[i].e_we);
      if (tbl[i].e_we) chk($sformatf("tbl%0d_waddr", i), vrf_waddr_o, tbl[i].e_wa);
      chk($sformatf("tbl%0d_pend", i), pend_valid_o, tbl[i].e_pv);
    end

    // Starvation: one queued entry (vd=7) behind a continuously valid pipe.
    for (int i = 0; i < 13; i++) begin
      set_in(1, 5'(12 + i), i == 0, 7, 0, 0, 0);
      pre_edge();
      chk($sformatf("starve_stall_c%0d", i), wb_stall_o, i == 9);
      post_edge();
      if (i == 9) chk("starve_waddr", vrf_waddr_o, 7);
      else        chk($sformatf("starve_pipe_c%0d", i), vrf_waddr_o, 12 + i);
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    pre_edge();
    post_edge();

    // Async reset between edges with the queue full.
    set_in(1, 2, 1, 1, 0, 0, 0);
    pre_edge(); post_edge();
    set_in(1, 3, 1, 2, 0, 0, 0);
    pre_edge(); post_edge();
    chk("mid_full_pend", pend_valid_o, 2'b11);
    set_in(0, 0, 0, 0, 1, 6, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", vrf_we_o, 0);
    chk("mid_rst_waddr", vrf_waddr_o, 0);
    chk("mid_rst_wdata", vrf_wdata_o, 0);
    chk("mid_rst_wbe", vrf_wbe_o, 0);
    chk("mid_rst_stall", wb_stall_o, 0);
    chk("mid_rst_pend", pend_valid_o, 0);
    chk("mid_rst_pend_vd", pend_vd_o, 0);
    chk("mid_rst_mc_ready", mc_ready_o, 0);
    chk("mid_rst_red_ready", red_ready_o, 1);
    set_in(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    // Random traffic; red and mc hold their payload until accepted.
    mv_hold = 0; rv_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!mv_hold) begin
        mc_valid_i = ($urandom_range(0, 3) == 0);
        mc_vd_i = 5'($urandom); mc_data_i = {$urandom, $urandom}; mc_be_i = 8'($urandom);
      end
      if (!rv_hold) begin
        red_valid_i = ($urandom_range(0, 2) == 0);
        red_vd_i = 5'($urandom); red_data_i = {$urandom, $urandom}; red_be_i = 8'($urandom);
      end
      pipe_valid_i = ((c / 400) % 2 == 1) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 9) < 6);
      pipe_vd_i = 5'($urandom); pipe_data_i = {$urandom, $urandom}; pipe_be_i = 8'($urandom);
      flush_i = ($urandom_range(0, 59) == 0);
      pre_edge();
      post_edge();
      mv_hold = mc_valid_i && !m_acc_m;
      rv_hold = red_valid_i && !m_acc_r;
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
